// File: rtl/stream_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stream_burst_pkg
// Brief   : Shared types and elaboration helpers for the stream burst reader.
// Revision: 1.0 - initial release
// ============================================================================
package stream_burst_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Bits needed to hold TIMEOUT-1, the terminal timer value.
  function automatic int timer_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic bit burst_len_legal(input int burst_len, input int count_w);
    return (burst_len >= 1) && (burst_len <= (2 ** count_w) - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ============================================================================
// Module  : stream_out_reg
// Brief   : One-stage valid/ready output register carrying data plus last.
// Revision: 1.0 - initial release
// ============================================================================
module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             stage_free,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             last,
  input  logic             ready
);

  assign stage_free = !valid || ready;

  // Data and last only change on a load, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      last  <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= load_last;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_burst_reader.sv
`default_nettype none
// ============================================================================
// Module  : stream_burst_reader
// Brief   : Drains a FIFO stream into TLAST-framed bursts, gated on occupancy,
//           with a timeout flush. STREAM_BURST_STATS_EN adds burst counters.
// Revision: 1.0 - initial release
// ============================================================================
module stream_burst_reader
  import stream_burst_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int COUNT_W   = 10,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 256
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [COUNT_W-1:0] count,
  input  logic [WIDTH-1:0]   in0_V_V_TDATA,
  input  logic               in0_V_V_TVALID,
  output logic               in0_V_V_TREADY,
  output logic [WIDTH-1:0]   out_V_V_TDATA,
  output logic               out_V_V_TVALID,
  input  logic               out_V_V_TREADY,
  output logic               out_V_V_TLAST,
  output logic               busy
`ifdef STREAM_BURST_STATS_EN
  ,
  output logic [31:0]        burst_cnt,
  output logic [15:0]        short_cnt
`endif
);

  localparam int TW = (timer_width(TIMEOUT) > COUNT_W) ? timer_width(TIMEOUT) : COUNT_W;
  localparam logic [COUNT_W-1:0] BURST_LEN_C = COUNT_W'(BURST_LEN);
  localparam logic [TW-1:0]      TIMER_LAST  = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit                 TIMEOUT_EN  = (TIMEOUT != 0);

  if (!burst_len_legal(BURST_LEN, COUNT_W)) begin : g_bad_burst_len
    $error("stream_burst_reader: BURST_LEN out of range 1..2^COUNT_W-1");
  end

  state_t             state;
  logic [COUNT_W-1:0] rem;
  logic [TW-1:0]      timer;
  logic               stage_free;
  logic               accept;
  logic               last_beat;
  logic               full_start;
  logic               short_start;
  logic               chain;

  assign in0_V_V_TREADY = (state == BURST) && stage_free;
  assign accept         = in0_V_V_TVALID && in0_V_V_TREADY;
  assign last_beat      = (rem == COUNT_W'(1));
  assign full_start     = (state == IDLE) && (count >= BURST_LEN_C);
  assign short_start    = (state == IDLE) && !full_start && TIMEOUT_EN &&
                          (count != '0) && (timer == TIMER_LAST);
  // count still includes the beat being popped, so more than a full burst
  // must remain for the next one to follow without an input bubble.
  assign chain          = (count > BURST_LEN_C);
  assign busy           = (state == BURST) || out_V_V_TVALID;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      rem   <= '0;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (full_start) begin
            rem   <= BURST_LEN_C;
            timer <= '0;
            state <= BURST;
          end else if (short_start) begin
            rem   <= count;
            timer <= '0;
            state <= BURST;
          end else if (count != '0) begin
            if (timer != '1) timer <= timer + TW'(1);
          end else begin
            timer <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            if (last_beat && chain) begin
              rem <= BURST_LEN_C;
            end else begin
              rem <= rem - COUNT_W'(1);
              if (last_beat) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .load       (accept),
    .load_data  (in0_V_V_TDATA),
    .load_last  (last_beat),
    .stage_free (stage_free),
    .data       (out_V_V_TDATA),
    .valid      (out_V_V_TVALID),
    .last       (out_V_V_TLAST),
    .ready      (out_V_V_TREADY)
  );

`ifdef STREAM_BURST_STATS_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      burst_cnt <= '0;
      short_cnt <= '0;
    end else begin
      if (out_V_V_TVALID && out_V_V_TREADY && out_V_V_TLAST && (burst_cnt != '1))
        burst_cnt <= burst_cnt + 32'd1;
      if (short_start && (short_cnt != '1))
        short_cnt <= short_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_burst_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_burst_reader
// Brief   : Scoreboard bench: FIFO model drives the reader, monitor checks beats.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_burst_reader;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n;
  logic [9:0] count;
  logic [7:0] in0_tdata;
  logic       in0_tvalid;
  logic       in0_tready;
  logic [7:0] out_tdata;
  logic       out_tvalid;
  logic       out_tready;
  logic       out_tlast;
  logic       busy;
`ifdef STREAM_BURST_STATS_EN
  logic [31:0] burst_cnt;
  logic [15:0] short_cnt;
`endif

  stream_burst_reader dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .count          (count),
    .in0_V_V_TDATA  (in0_tdata),
    .in0_V_V_TVALID (in0_tvalid),
    .in0_V_V_TREADY (in0_tready),
    .out_V_V_TDATA  (out_tdata),
    .out_V_V_TVALID (out_tvalid),
    .out_V_V_TREADY (out_tready),
    .out_V_V_TLAST  (out_tlast),
    .busy           (busy)
`ifdef STREAM_BURST_STATS_EN
    ,
    .burst_cnt      (burst_cnt),
    .short_cnt      (short_cnt)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         rel_cnt = 0;
  logic [7:0] fifo_q[$];
  logic [8:0] exp_q[$];
  int         acc_cyc[$];
  logic       acc = 1'b0;
  logic [7:0] acc_data = 8'h00;
  logic       rdy_toggle = 1'b0;
  logic       ovr_en = 1'b0;
  logic [9:0] ovr = 10'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic last);
    fifo_q.push_back(d);
    exp_q.push_back({last, d});
  endtask

  // n items; TLAST every grp-th beat and on the final beat.
  task automatic push_burst(input int n, input logic [7:0] base, input int grp);
    for (int i = 0; i < n; i++)
      add(base + 8'(i), ((i % grp) == grp - 1) || (i == n - 1));
  endtask

  task automatic drive();
    in0_tvalid = (fifo_q.size() != 0);
    in0_tdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    count      = ovr_en ? ovr : 10'(fifo_q.size());
    #1;
    acc      = in0_tvalid && in0_tready;
    acc_data = in0_tdata;
  endtask

  task automatic step();
    logic       was_acc;
    logic [7:0] d;
    was_acc = acc;
    d       = acc_data;
    @(posedge ap_clk);
    cyc++;
    if (was_acc) begin
      void'(fifo_q.pop_front());
      acc_cyc.push_back(cyc);
    end
    #1;
    if (was_acc) begin
      chk("accept->out valid", 32'(out_tvalid), 32'd1);
      chk("accept->out data", 32'(out_tdata), 32'(d));
    end
    out_tready = rdy_toggle ? ~out_tready : 1'b1;
    drive();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_tvalid || fifo_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({name, " drained in budget"}, 32'(n < budget), 32'd1);
    chk({name, " idle busy"}, 32'(busy), 32'd0);
  endtask

  // Monitor: scoreboard pops on every released beat, plus stall stability.
  logic       stalled = 1'b0;
  logic [7:0] held_data = 8'h00;
  logic       held_last = 1'b0;
  always @(negedge ap_clk) begin
    logic [8:0] e;
    if (ap_rst_n) begin
      if (stalled && out_tvalid) begin
        chk("stall data stable", 32'(out_tdata), 32'(held_data));
        chk("stall last stable", 32'(out_tlast), 32'(held_last));
      end
      if (out_tvalid && !out_tready)
        chk("in0 ready while stalled", 32'(in0_tready), 32'd0);
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected beat: got data 0x%0h last %0b, none expected", out_tdata, out_tlast);
        end else begin
          e = exp_q.pop_front();
          chk("beat data", 32'(out_tdata), 32'(e[7:0]));
          chk("beat last", 32'(out_tlast), 32'(e[8]));
          rel_cnt++;
        end
      end
    end
    stalled   = out_tvalid && !out_tready;
    held_data = out_tdata;
    held_last = out_tlast;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ap_rst_n   = 1'b0;
    out_tready = 1'b1;
    in0_tvalid = 1'b0;
    in0_tdata  = 8'h00;
    count      = 10'd0;
    #2;
    chk("reset out valid", 32'(out_tvalid), 32'd0);
    chk("reset out last", 32'(out_tlast), 32'd0);
    chk("reset out data", 32'(out_tdata), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset in0 ready", 32'(in0_tready), 32'd0);
    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    drive();
    step();

    // Full burst: occupancy ramps to 16, one item per cycle.
    for (int i = 0; i < 16; i++) begin
      add(8'(i), i == 15);
      drive();
      step();
    end
    drain("full burst", 100);

    // Backpressure: ready toggles every cycle.
    rdy_toggle = 1'b1;
    push_burst(16, 8'h40, 16);
    drive();
    drain("backpressure", 200);
    rdy_toggle = 1'b0;
    step();

    // Timeout flush of 5 items.
    push_burst(5, 8'h80, 16);
    drive();
    n = 0;
    while (!in0_tready && n < 400) begin
      step();
      n++;
    end
    chk("timeout start cycles", 32'(n), 32'd256);
    drain("timeout", 100);

    // Back-to-back: 16 + 16 contiguous, then an 8-beat flush.
    acc_cyc.delete();
    push_burst(40, 8'hC0, 16);
    drive();
    drain("back-to-back", 800);
    if (acc_cyc.size() >= 32)
      chk("b2b accepts contiguous", 32'(acc_cyc[31] - acc_cyc[0]), 32'd31);
    else
      chk("b2b accept count", 32'(acc_cyc.size()), 32'd40);

    // Count drops mid-burst: burst must still complete 16 beats.
    acc_cyc.delete();
    push_burst(20, 8'h10, 16);
    drive();
    n = 0;
    while (acc_cyc.size() < 4 && n < 50) begin
      step();
      n++;
    end
    ovr_en = 1'b1;
    ovr    = 10'd4;
    drive();
    n = 0;
    while (acc_cyc.size() < 16 && n < 50) begin
      step();
      n++;
    end
    chk("burst done despite count drop", 32'(acc_cyc.size()), 32'd16);
    ovr_en = 1'b0;
    drive();
    drain("count drop", 600);

`ifdef STREAM_BURST_STATS_EN
    chk("stats burst_cnt", burst_cnt, 32'd8);
    chk("stats short_cnt", 32'(short_cnt), 32'd3);
`endif

    // Async reset after 7 beats released.
    rel_cnt = 0;
    push_burst(16, 8'h50, 16);
    drive();
    n = 0;
    while (rel_cnt < 7 && n < 60) begin
      step();
      n++;
    end
    chk("beats before reset", 32'(rel_cnt), 32'd7);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("async rst out valid", 32'(out_tvalid), 32'd0);
    chk("async rst out last", 32'(out_tlast), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    exp_q.delete();
    fifo_q.delete();
    acc = 1'b0;
    drive();
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    drive();
    repeat (3) step();
    chk("post reset busy", 32'(busy), 32'd0);
    chk("post reset in0 ready", 32'(in0_tready), 32'd0);
    chk("post reset timer", 32'(dut.timer), 32'd0);
`ifdef STREAM_BURST_STATS_EN
    chk("post reset burst_cnt", burst_cnt, 32'd0);
    chk("post reset short_cnt", 32'(short_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
